// File: rtl/uart_defs_pkg.sv
// rtl/uart_defs_pkg.sv - shared UART definitions: receiver states, oversample rate, defaults
package uart_defs_pkg;

    // Receiver states, listed in the order a frame visits them
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Ticks per bit period; also used by the transmitter
    localparam int OVERSAMPLE  = 16;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

    // Clock cycles per oversample tick (integer floor)
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_deser_baud_tick_gen.sv
// rtl/uart_rx_deser_baud_tick_gen.sv - free-running divider producing the 16x baud tick
module baud_tick_gen #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; the tick marks the wrapping cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 16x oversampling 8N1 UART receiver with frame error detection
module uart_rx_deser
    import uart_defs_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 115200,
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int NW  = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [3:0]    S_MID     = 4'd7;
    localparam logic [3:0]    S_LAST    = 4'd15;
    localparam logic [3:0]    S_STOP    = 4'(SB_TICK - 1);

    logic            w_tick;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;

    rx_state_t       r_state;
    rx_state_t       w_next;

    logic [3:0]      r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_err;

    logic            w_s_clr;
    logic            w_s_inc;
    logic            w_n_clr;
    logic            w_n_inc;
    logic            w_shift;
    logic            w_load;
    logic            w_err;

    baud_tick_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; IDLE and WAIT_HIGH react every clock, others only on ticks
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) w_next = ST_START;
            end
            ST_START: begin
                if (w_tick && r_s == S_MID) w_next = w_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && r_s == S_LAST && r_n == N_LAST) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick && r_s == S_STOP) w_next = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (w_rx_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state and sampling point
    always_comb begin
        w_s_clr = 1'b0;
        w_s_inc = 1'b0;
        w_n_clr = 1'b0;
        w_n_inc = 1'b0;
        w_shift = 1'b0;
        w_load  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) w_s_clr = 1'b1;
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == S_MID) begin
                        if (!w_rx_s) begin
                            w_s_clr = 1'b1;
                            w_n_clr = 1'b1;
                        end
                    end else begin
                        w_s_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_shift = 1'b1;
                        w_s_clr = 1'b1;
                        if (r_n != N_LAST) w_n_inc = 1'b1;
                    end else begin
                        w_s_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == S_STOP) begin
                        w_load = w_rx_s;
                        w_err  = ~w_rx_s;
                    end else begin
                        w_s_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Tick/bit counters, shift register, output byte and registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_n    <= '0;
            r_b    <= '0;
            r_dout <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_s_clr) begin
                r_s <= '0;
            end else if (w_s_inc) begin
                r_s <= r_s + 1'b1;
            end
            if (w_n_clr) begin
                r_n <= '0;
            end else if (w_n_inc) begin
                r_n <= r_n + 1'b1;
            end
            if (w_shift) r_b <= {w_rx_s, r_b[DBIT-1:1]};
            if (w_load) r_dout <= r_b;
            r_done <= w_load;
            r_err  <= w_err;
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_err;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - self-checking bench for uart_rx_deser against a frame-level model
module tb_uart_rx_deser;

    localparam int BIT_CLK = 160;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int compared = 0;
    int mismatched = 0;

    // Observations gathered by the monitor
    logic [7:0] obs_q[$];
    int         done_cyc[$];
    int         err_cnt = 0;
    int         viol = 0;
    int         cyc = 0;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_dout = 8'h00;

    // Frame-level model: bytes expected, frame errors expected, byte on dout
    logic [7:0] exp_q[$];
    int         exp_err = 0;
    logic [7:0] exp_dout = 8'h00;

    uart_rx_deser #(
        .CLK_HZ  (1_600_000),
        .BAUD    (10_000),
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge: record pulses and protocol violations
    always @(negedge clk) begin
        cyc++;
        if (rx_done_tick) begin
            obs_q.push_back(dout);
            done_cyc.push_back(cyc);
        end
        if (frame_err) err_cnt++;
        if (rx_done_tick && frame_err) viol++;
        if ((rx_done_tick && prev_done) || (frame_err && prev_err)) viol++;
        if (!rst && !prev_rst && !rx_done_tick && dout !== prev_dout) viol++;
        prev_done = rx_done_tick;
        prev_err  = frame_err;
        prev_rst  = rst;
        prev_dout = dout;
    end

    task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop);
        rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bclk) @(negedge clk);
        end
        rx = stop;
        repeat (bclk) @(negedge clk);
    endtask

    task automatic good_frame(input logic [7:0] d, input int bclk);
        send_frame(d, bclk, 1'b1);
        exp_q.push_back(d);
        exp_dout = d;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        #2;
        compared++;
        assert (obs_q.size() === exp_q.size()) else begin
            mismatched++;
            $error("FAIL %s done_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
        end
        compared++;
        assert (err_cnt === exp_err) else begin
            mismatched++;
            $error("FAIL %s frame_err_count: got %0d expected %0d", tag, err_cnt, exp_err);
        end
        compared++;
        assert (dout === exp_dout) else begin
            mismatched++;
            $error("FAIL %s dout: got %02h expected %02h", tag, dout, exp_dout);
        end
        if (obs_q.size() > 0 && obs_q.size() == exp_q.size()) begin
            compared++;
            assert (obs_q[$] === exp_q[$]) else begin
                mismatched++;
                $error("FAIL %s last_byte: got %02h expected %02h", tag, obs_q[$], exp_q[$]);
            end
        end
        compared++;
        assert (viol === 0) else begin
            mismatched++;
            $error("FAIL %s pulse_rules: got %0d violations expected 0", tag, viol);
        end
    endtask

    initial begin
        int n0;
        int diff;
        int bclk;
        logic [7:0] d;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        compared++;
        assert (dout === 8'h00) else begin
            mismatched++;
            $error("FAIL reset_dout: got %02h expected 00", dout);
        end
        compared++;
        assert (rx_done_tick === 1'b0) else begin
            mismatched++;
            $error("FAIL reset_done: got %b expected 0", rx_done_tick);
        end
        compared++;
        assert (frame_err === 1'b0) else begin
            mismatched++;
            $error("FAIL reset_err: got %b expected 0", frame_err);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(50);

        // Single clean frame
        good_frame(8'h55, BIT_CLK);
        idle(40);
        check_all("frame_55");

        // Back-to-back frames with no idle gap
        n0 = done_cyc.size();
        good_frame(8'h04, BIT_CLK);
        good_frame(8'h41, BIT_CLK);
        idle(40);
        check_all("b2b");
        compared++;
        if (done_cyc.size() >= n0 + 2) begin
            diff = done_cyc[n0+1] - done_cyc[n0];
            assert (diff >= 1590 && diff <= 1610) else begin
                mismatched++;
                $error("FAIL b2b_spacing: got %0d clocks expected 1600", diff);
            end
        end else begin
            mismatched++;
            $error("FAIL b2b_spacing: got %0d pulses expected 2", done_cyc.size() - n0);
        end
        compared++;
        assert (obs_q.size() >= 2 && obs_q[obs_q.size()-2] === 8'h04) else begin
            mismatched++;
            $error("FAIL b2b_first: got %0d pulses/last-but-one mismatch expected 04", obs_q.size());
        end

        // Short glitch on the idle line
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(300);
        check_all("glitch");

        // Stop bit low followed by a held break, then recovery
        send_frame(8'hA3, BIT_CLK, 1'b0);
        repeat (2000 - BIT_CLK) @(negedge clk);
        exp_err++;
        idle(100);
        check_all("break");
        good_frame(8'h3C, BIT_CLK);
        idle(40);
        check_all("after_break");

        // Asynchronous reset in the middle of the data bits of 0xFF
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_dout = 8'h00;
        compared++;
        assert (dout === 8'h00 && rx_done_tick === 1'b0 && frame_err === 1'b0) else begin
            mismatched++;
            $error("FAIL async_reset: got dout=%02h done=%b err=%b expected 00/0/0",
                   dout, rx_done_tick, frame_err);
        end
        repeat (20) @(negedge clk);
        rst = 1'b0;
        idle(6 * BIT_CLK);
        check_all("reset_mid");
        good_frame(8'h12, BIT_CLK);
        idle(40);
        check_all("after_reset");

        // Baud skew of +/-2.5%
        good_frame(8'hC9, 164);
        idle(60);
        check_all("skew_slow");
        good_frame(8'hC9, 156);
        idle(60);
        check_all("skew_fast");

        // Random bytes, random skew, random gaps
        for (int k = 0; k < 6; k++) begin
            d    = 8'($urandom_range(0, 255));
            bclk = 156 + 4 * $urandom_range(0, 2);
            good_frame(d, bclk);
            idle($urandom_range(0, 40));
            check_all("random");
        end

        // Full history of delivered bytes
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            assert (i < obs_q.size() && obs_q[i] === exp_q[i]) else begin
                mismatched++;
                $error("FAIL history[%0d]: got %02h expected %02h", i,
                       (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-parallel UART receiver for the crypter datapath. Oversamples the asynchronous `rx` line at 16× baud, recovers 8N1 frames LSB-first, and presents each good byte on `dout` with a one-cycle `rx_done_tick`. It sits directly upstream of the RX interface buffer: `rx_done_tick` drives that buffer's `set_flag` and `dout` drives its `data_in`. Byte values are not interpreted here; EOT (0x04) detection is downstream.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115200: line rate.
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: oversample ticks spent in the stop bit (16 = 1 stop bit).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `dout`  out  DBIT  last good received byte, registered.
- `rx_done_tick`  out  1  one-cycle pulse, `dout` valid and newly updated.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low.

## Operation
- Baud tick: `DIV = CLK_HZ / (BAUD*16)`, integer floor (54 at defaults).
  - Free-running counter 0..DIV-1.
  - `tick` is high for one cycle when the counter wraps.
- Input sync: 2-flop synchronizer on `rx`, both flops reset to 1. The FSM sees only `rx_s`.
- Counters: `s` counts ticks (4 bit); `n` counts data bits (log2 DBIT bits); `b` is the shift register (DBIT bits).
- FSM states, in the order a frame visits them:
  - IDLE: when `rx_s`==0, clear `s` and go to START. Evaluated every clock, independent of `tick`.
  - START: on `tick` with `s`==7 (mid start bit):
    - `rx_s`==0: clear `s` and `n`, go to DATA.
    - `rx_s`==1: glitch, return to IDLE with no output.
    - On other ticks, increment `s`.
  - DATA: on `tick` with `s`==15, shift right with `b <= {rx_s, b[DBIT-1:1]}` (LSB first) and clear `s`.
    - If `n`==DBIT-1, go to STOP; otherwise increment `n`.
    - On other ticks, increment `s`.
  - STOP: on `tick` with `s`==SB_TICK-1:
    - `rx_s`==1: load `dout <= b`, pulse `rx_done_tick`, go to IDLE.
    - `rx_s`==0: pulse `frame_err`, leave `dout` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. A held break produces exactly one `frame_err`.
- `rx_done_tick` and `frame_err` are never high in the same cycle and never high for two consecutive cycles.
- Reset values: IDLE; `s`, `n`, `b`, `dout`, `rx_done_tick`, `frame_err`, baud counter all 0.
- Reset mid-frame: the partial byte is discarded and no pulse is emitted. After release, a line still low mid-frame may be taken as a start bit. Such a frame either fails the glitch check or is delivered or flagged like any other frame.

## Timing
- Latency to IDLE exit: 2 clocks from an `rx` falling edge (synchronizer).
- Start validation at ~8 ticks; data bits sampled every 16 ticks near bit center.
- `rx_done_tick` / `frame_err`: the clock after the STOP-sampling tick. `dout` is updated in that same cycle and holds until the next good frame.
- A completed frame returns to IDLE at mid stop bit, so back-to-back frames with zero idle gap are received.
- Tolerance: about ±3% combined baud mismatch.
- No backpressure. The consumer must read `dout` before the next `rx_done_tick`, one frame time later at minimum.

## Structure
- Shared include `uart_defs`:
  - FSM state encodings (IDLE, START, DATA, STOP, WAIT_HIGH).
  - `OVERSAMPLE`=16 and default DBIT/SB_TICK, also used by the TX side.
- Sub-module `baud_tick_gen`:
  - Parameter DIV; ports `clk`, `rst`, output `tick`.
  - Shared with the UART transmitter.
- Top: synchronizer, FSM, datapath registers.

## Test plan
Common setup: CLK_HZ=1_600_000, BAUD=10_000, so DIV=10 and 160 clocks per bit.
- Frame 0x55, stop=1 → exactly one `rx_done_tick`, `dout`=0x55, `frame_err` stays 0.
- Frame 0x04 immediately followed (zero gap) by 0x41 → two pulses one frame apart, `dout`=0x04 then 0x41.
- 30-clock low glitch on idle line → returns to IDLE, no pulses, `dout` unchanged.
- Frame 0xA3 with stop bit low, line held low 2000 clocks, then high, then frame 0x3C:
  - Exactly one `frame_err` and no `rx_done_tick` for the bad frame; `dout` keeps its prior value.
  - 0x3C then received normally.
- `rst` asserted mid-DATA of frame 0xFF → outputs go to 0 immediately (asynchronous), no pulse; the next clean 0x12 frame is received correctly.
- Baud skew: 0xC9 sent at +2.5% and −2.5% bit period → `dout`=0xC9 in both cases.
